// File: rtl/seg_scan_if.sv
// Display-update write port of seg_scan_ctrl: valid/ready handshake plus the
// digit fields that are latched on a transfer.
interface seg_scan_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic [3:0]  wr_blank;
    logic [3:0]  wr_blink;
    logic [2:0]  wr_bright;

    modport master (
        output wr_valid, wr_data, wr_dp, wr_blank, wr_blink, wr_bright,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_data, wr_dp, wr_blank, wr_blink, wr_bright,
        output wr_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display: frame-synchronous
// update commit, per-slot anti-ghosting blank, brightness PWM and per-digit blink.
module seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 1200,
    parameter int unsigned BLANK_CYC    = 64,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  wr,
    output logic [7:0] seg,
    output logic [3:0] seg_dig,
    output logic       frame_done
);

    localparam int unsigned CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned ON_W    = $clog2(SCAN_DIV + 1) + 1;
    localparam int unsigned ON_STEP = (SCAN_DIV - BLANK_CYC) / 8;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic [2:0]  bright;
    } disp_t;

    typedef enum logic [1:0] {PH_BLANK, PH_ON, PH_OFF} phase_t;

    localparam disp_t DISP_RST = '{data: 16'h0, dp: 4'h0, blank: 4'hF, blink: 4'h0, bright: 3'd7};

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_dig;
    logic [FC_W-1:0]  r_fc;
    logic             r_blink_ph;
    logic             r_pend;
    disp_t            r_buf;
    disp_t            r_disp;
    phase_t           r_phase;
    logic [7:0]       r_seg;
    logic [3:0]       r_seg_dig;
    logic             r_fd;

    logic             w_wrap;
    logic             w_boundary;
    logic             w_xfer;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_dig_nxt;
    disp_t            w_disp_nxt;
    phase_t           w_phase_nxt;
    logic [ON_W-1:0]  w_on_end;
    logic [3:0]       w_nib;
    logic             w_sup;
    logic [7:0]       w_seg_nxt;
    logic [3:0]       w_seg_dig_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign w_wrap     = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_boundary = w_wrap && (r_dig == 2'd3);
    assign w_xfer     = wr.wr_valid && !r_pend;

    assign wr.wr_ready = ~r_pend;
    assign seg         = r_seg;
    assign seg_dig     = r_seg_dig;
    assign frame_done  = r_fd;

    // Next slot position, phase of that position, and the outputs for the current one.
    always_comb begin
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_dig_nxt     = r_dig;
        w_disp_nxt    = r_disp;
        w_phase_nxt   = PH_OFF;
        w_on_end      = '0;
        w_nib         = '0;
        w_sup         = 1'b0;
        w_seg_nxt     = 8'hFF;
        w_seg_dig_nxt = 4'hF;

        if (w_wrap) begin
            w_cnt_nxt = '0;
            w_dig_nxt = r_dig + 2'd1;
        end
        if (w_boundary && r_pend) begin
            w_disp_nxt = r_buf;
        end

        // Phase uses the brightness that will be live when the next cycle is displayed.
        w_on_end = ON_W'(BLANK_CYC) + (ON_W'(w_disp_nxt.bright) + ON_W'(1)) * ON_W'(ON_STEP);
        if (ON_W'(w_cnt_nxt) < ON_W'(BLANK_CYC)) begin
            w_phase_nxt = PH_BLANK;
        end else if (ON_W'(w_cnt_nxt) < w_on_end) begin
            w_phase_nxt = PH_ON;
        end

        w_nib = r_disp.data[{r_dig, 2'b00} +: 4];
        w_sup = r_disp.blank[r_dig] | (r_disp.blink[r_dig] & ~r_blink_ph);
        if ((r_phase == PH_ON) && !w_sup) begin
            w_seg_dig_nxt = ~(4'b0001 << r_dig);
            w_seg_nxt     = {~r_disp.dp[r_dig], hex7(w_nib)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dig      <= 2'd0;
            r_fc       <= '0;
            r_blink_ph <= 1'b1;
            r_pend     <= 1'b0;
            r_buf      <= '0;
            r_disp     <= DISP_RST;
            r_phase    <= PH_BLANK;
            r_seg      <= 8'hFF;
            r_seg_dig  <= 4'hF;
            r_fd       <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_dig     <= w_dig_nxt;
            r_phase   <= w_phase_nxt;
            r_disp    <= w_disp_nxt;
            r_seg     <= w_seg_nxt;
            r_seg_dig <= w_seg_dig_nxt;
            r_fd      <= w_boundary;

            if (w_boundary) begin
                if (r_fc == FC_W'(BLINK_FRAMES - 1)) begin
                    r_fc       <= '0;
                    r_blink_ph <= ~r_blink_ph;
                end else begin
                    r_fc <= r_fc + FC_W'(1);
                end
            end

            // A write landing on a boundary with nothing pending waits a full frame.
            if (w_boundary && r_pend) begin
                r_pend <= 1'b0;
            end else if (w_xfer) begin
                r_pend <= 1'b1;
                r_buf  <= '{data: wr.wr_data, dp: wr.wr_dp, blank: wr.wr_blank,
                            blink: wr.wr_blink, bright: wr.wr_bright};
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=16, BLANK_CYC=4, BLINK_FRAMES=2
// (ON_STEP=1, so a slot is 4 blank cycles then bright+1 lit cycles).
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg;
    logic [3:0] seg_dig;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_if u_if ();

    seg_scan_ctrl #(.SCAN_DIV(16), .BLANK_CYC(4), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (u_if),
        .seg        (seg),
        .seg_dig    (seg_dig),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Frame cycles 0..62 (cycle 63 is always OFF); sample j lands one cycle after frame cycle j.
    logic [7:0] cap_seg [63];
    logic [3:0] cap_dig [63];
    logic [7:0] exp_seg [63];
    logic [3:0] exp_dig [63];

    task automatic build_exp(input logic [15:0] data, input logic [3:0] dp, input logic [3:0] blank,
                             input logic [3:0] blink, input logic [2:0] br, input logic bp);
        int d, c;
        logic [3:0] nib, onehot;
        logic [7:0] h;
        logic lit;
        for (int j = 0; j < 63; j++) begin
            d      = j / 16;
            c      = j % 16;
            nib    = data[d*4 +: 4];
            h      = HEX[nib];
            lit    = (c >= 4) && (c < 5 + int'(br)) && !blank[d] && !(blink[d] && !bp);
            onehot = 4'b0001;
            onehot = onehot << d;
            exp_seg[j] = lit ? {~dp[d], h[6:0]} : 8'hFF;
            exp_dig[j] = lit ? ~onehot : 4'hF;
        end
    endtask

    // Call at the negedge where frame_done is high.
    task automatic capture_frame();
        for (int j = 0; j < 63; j++) begin
            @(negedge clk);
            cap_seg[j] = seg;
            cap_dig[j] = seg_dig;
        end
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL wait_fd: frame_done=%b after %0d cycles, required 1", frame_done, n);
        end
    endtask

    task automatic do_write(input logic [15:0] data, input logic [3:0] dp, input logic [3:0] blank,
                            input logic [3:0] blink, input logic [2:0] br);
        u_if.wr_data   = data;
        u_if.wr_dp     = dp;
        u_if.wr_blank  = blank;
        u_if.wr_blink  = blink;
        u_if.wr_bright = br;
        u_if.wr_valid  = 1'b1;
        @(negedge clk);
        u_if.wr_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({seg, seg_dig, frame_done, u_if.wr_ready} !== {8'hFF, 4'hF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: seg=%h dig=%h fd=%b rdy=%b, required FF F 0 1",
                     seg, seg_dig, frame_done, u_if.wr_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({seg, seg_dig, u_if.wr_ready} !== {8'hFF, 4'hF, 1'b1}) begin
                errors++;
                $display("FAIL dark_after_reset[%0d]: seg=%h dig=%h rdy=%b, required FF F 1",
                         i, seg, seg_dig, u_if.wr_ready);
            end
        end
    endtask

    task automatic test_basic_write();
        int n;
        do_write(16'h1234, 4'b0001, 4'h0, 4'h0, 3'd7);
        checks++;
        if (u_if.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_accept: wr_ready=%b, required 0", u_if.wr_ready);
        end
        // Second write held while the first is pending.
        u_if.wr_data  = 16'hABCD;
        u_if.wr_dp    = 4'b1000;
        u_if.wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (u_if.wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_pending[%0d]: wr_ready=%b, required 0", i, u_if.wr_ready);
            end
        end
        wait_fd(n);
        checks++;
        if (u_if.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_commit: wr_ready=%b, required 1", u_if.wr_ready);
        end
        fork
            begin
                @(negedge clk);
                u_if.wr_valid = 1'b0;
            end
        join_none
        build_exp(16'h1234, 4'b0001, 4'h0, 4'h0, 3'd7, 1'b1);
        capture_frame();
        for (int j = 0; j < 63; j++) begin
            checks++;
            if (cap_seg[j] !== exp_seg[j] || cap_dig[j] !== exp_dig[j]) begin
                errors++;
                $display("FAIL frame_1234[%0d]: seg=%h dig=%h, required seg=%h dig=%h",
                         j, cap_seg[j], cap_dig[j], exp_seg[j], exp_dig[j]);
            end
        end
        checks++;
        if (u_if.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL second_accept: wr_ready=%b, required 0", u_if.wr_ready);
        end
        wait_fd(n);
        build_exp(16'hABCD, 4'b1000, 4'h0, 4'h0, 3'd7, 1'b1);
        capture_frame();
        for (int j = 0; j < 63; j++) begin
            checks++;
            if (cap_seg[j] !== exp_seg[j] || cap_dig[j] !== exp_dig[j]) begin
                errors++;
                $display("FAIL frame_abcd[%0d]: seg=%h dig=%h, required seg=%h dig=%h",
                         j, cap_seg[j], cap_dig[j], exp_seg[j], exp_dig[j]);
            end
        end
    endtask

    // Starts on the boundary cycle: the write lands on the commit edge and must wait a frame.
    task automatic test_no_bypass();
        int n;
        do_write(16'h5678, 4'h0, 4'h0, 4'h0, 3'd0);
        checks++;
        if ({frame_done, u_if.wr_ready} !== 2'b10) begin
            errors++;
            $display("FAIL boundary_write: fd=%b rdy=%b, required 1 0", frame_done, u_if.wr_ready);
        end
        build_exp(16'hABCD, 4'b1000, 4'h0, 4'h0, 3'd7, 1'b1);
        capture_frame();
        for (int j = 0; j < 63; j++) begin
            checks++;
            if (cap_seg[j] !== exp_seg[j] || cap_dig[j] !== exp_dig[j]) begin
                errors++;
                $display("FAIL no_bypass[%0d]: seg=%h dig=%h, required seg=%h dig=%h",
                         j, cap_seg[j], cap_dig[j], exp_seg[j], exp_dig[j]);
            end
        end
        wait_fd(n);
        build_exp(16'h5678, 4'h0, 4'h0, 4'h0, 3'd0, 1'b1);
        capture_frame();
        for (int j = 0; j < 63; j++) begin
            checks++;
            if (cap_seg[j] !== exp_seg[j] || cap_dig[j] !== exp_dig[j]) begin
                errors++;
                $display("FAIL bright0[%0d]: seg=%h dig=%h, required seg=%h dig=%h",
                         j, cap_seg[j], cap_dig[j], exp_seg[j], exp_dig[j]);
            end
        end
    endtask

    task automatic test_brightness();
        int n;
        do_write(16'h0F0E, 4'h0, 4'h0, 4'h0, 3'd3);
        wait_fd(n);
        build_exp(16'h0F0E, 4'h0, 4'h0, 4'h0, 3'd3, 1'b1);
        capture_frame();
        for (int j = 0; j < 63; j++) begin
            checks++;
            if (cap_seg[j] !== exp_seg[j] || cap_dig[j] !== exp_dig[j]) begin
                errors++;
                $display("FAIL bright3[%0d]: seg=%h dig=%h, required seg=%h dig=%h",
                         j, cap_seg[j], cap_dig[j], exp_seg[j], exp_dig[j]);
            end
        end
    endtask

    task automatic test_blank();
        int n;
        do_write(16'h8888, 4'h0, 4'b0101, 4'h0, 3'd7);
        wait_fd(n);
        build_exp(16'h8888, 4'h0, 4'b0101, 4'h0, 3'd7, 1'b1);
        capture_frame();
        for (int j = 0; j < 63; j++) begin
            checks++;
            if (cap_seg[j] !== exp_seg[j] || cap_dig[j] !== exp_dig[j]) begin
                errors++;
                $display("FAIL blank_0101[%0d]: seg=%h dig=%h, required seg=%h dig=%h",
                         j, cap_seg[j], cap_dig[j], exp_seg[j], exp_dig[j]);
            end
        end
    endtask

    // Blink phase after boundaries 1..5 from reset: 1,0,0,1,1.
    task automatic test_blink();
        int n;
        logic [4:0] bp_seq = 5'b11001;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_write(16'h4321, 4'h0, 4'h0, 4'b1000, 3'd7);
        for (int k = 0; k < 5; k++) begin
            wait_fd(n);
            build_exp(16'h4321, 4'h0, 4'h0, 4'b1000, 3'd7, bp_seq[k]);
            capture_frame();
            for (int j = 0; j < 63; j++) begin
                checks++;
                if (cap_seg[j] !== exp_seg[j] || cap_dig[j] !== exp_dig[j]) begin
                    errors++;
                    $display("FAIL blink_f%0d[%0d]: seg=%h dig=%h, required seg=%h dig=%h",
                             k, j, cap_seg[j], cap_dig[j], exp_seg[j], exp_dig[j]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_write(16'h5555, 4'hF, 4'h0, 4'h0, 3'd7);
        repeat (37) @(negedge clk);
        checks++;
        if ({seg, seg_dig, u_if.wr_ready} !== {8'hB0, 4'b1011, 1'b0}) begin
            errors++;
            $display("FAIL pre_reset_on: seg=%h dig=%h rdy=%b, required B0 B 0",
                     seg, seg_dig, u_if.wr_ready);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({seg, seg_dig, frame_done, u_if.wr_ready} !== {8'hFF, 4'hF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: seg=%h dig=%h fd=%b rdy=%b, required FF F 0 1",
                     seg, seg_dig, frame_done, u_if.wr_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_fd(n);
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL restart_align: first frame_done after %0d cycles, required 64", n);
        end
        build_exp(16'h0000, 4'h0, 4'hF, 4'h0, 3'd7, 1'b1);
        capture_frame();
        for (int j = 0; j < 63; j++) begin
            checks++;
            if (cap_seg[j] !== exp_seg[j] || cap_dig[j] !== exp_dig[j]) begin
                errors++;
                $display("FAIL pending_lost[%0d]: seg=%h dig=%h, required seg=%h dig=%h",
                         j, cap_seg[j], cap_dig[j], exp_seg[j], exp_dig[j]);
            end
        end
    endtask

    initial begin
        u_if.wr_valid  = 1'b0;
        u_if.wr_data   = 16'h0;
        u_if.wr_dp     = 4'h0;
        u_if.wr_blank  = 4'h0;
        u_if.wr_blink  = 4'h0;
        u_if.wr_bright = 3'd0;
        test_reset();
        test_basic_write();
        test_no_bypass();
        test_brightness();
        test_blank();
        test_blink();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
